// File: rtl/phy_tx_ctrl.sv
// Link-state controller for the PHY transmit path: drives phy_tx idle and flags recirc leaks.
// Optional per-lane activity counters are built when LANE_CNT_EN is defined.
module phy_tx_ctrl #(
    parameter int UMB_W = 4,
    parameter int GUARD = 1
) (
    input  logic             clk_f,
    input  logic             reset,
    input  logic             init,
    input  logic [UMB_W-1:0] umbral_idle,
    input  logic             valid_0,
    input  logic             valid_1,
    input  logic             valid_2,
    input  logic             valid_3,
    input  logic             valid_r_0,
    input  logic             valid_r_1,
    input  logic             valid_r_2,
    input  logic             valid_r_3,
    output logic             idle,
    output logic [4:0]       state,
    output logic             error
`ifdef LANE_CNT_EN
    ,
    output logic [7:0]       cnt_0,
    output logic [7:0]       cnt_1,
    output logic [7:0]       cnt_2,
    output logic [7:0]       cnt_3
`endif
);

    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t           r_state;
    logic             r_idle;
    logic             r_error;
    logic [UMB_W-1:0] r_umbral;
    logic [UMB_W-1:0] r_quiet;
    logic [GW-1:0]    r_guard;

    logic [3:0]       w_valid;
    logic             w_any_v;
    logic             w_any_r;
    logic             w_leak;
    logic [UMB_W:0]   w_quiet_inc;
    logic             w_quiet_hit;
    logic [UMB_W-1:0] w_umb_load;

    assign w_valid     = {valid_3, valid_2, valid_1, valid_0};
    assign w_any_v     = |w_valid;
    assign w_any_r     = valid_r_0 | valid_r_1 | valid_r_2 | valid_r_3;
    assign w_leak      = (r_guard == '0) && w_any_r;
    assign w_quiet_inc = {1'b0, r_quiet} + {{UMB_W{1'b0}}, 1'b1};
    assign w_quiet_hit = (w_quiet_inc == {1'b0, r_umbral});
    // A zero threshold would never match quiet+1, so it is clamped to the minimum of 1.
    assign w_umb_load  = (umbral_idle == '0) ? UMB_W'(1) : umbral_idle;

    assign state = r_state;
    assign idle  = r_idle;
    assign error = r_error;

    always_ff @(posedge clk_f) begin
        if (reset) begin
            r_state  <= ST_RESET;
            r_idle   <= 1'b1;
            r_error  <= 1'b0;
            r_umbral <= '1;
            r_quiet  <= '0;
            r_guard  <= '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state <= ST_INIT;
                    r_idle  <= 1'b1;
                end
                ST_INIT: begin
                    r_idle <= 1'b1;
                    if (init) begin
                        r_umbral <= w_umb_load;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (init) begin
                        r_state <= ST_INIT;
                        r_idle  <= 1'b1;
                    end else if (w_any_v) begin
                        r_state <= ST_ACTIVE;
                        r_idle  <= 1'b0;
                        r_quiet <= '0;
                        r_guard <= GW'(GUARD);
                    end else begin
                        r_idle <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (w_any_v) begin
                        r_quiet <= '0;
                    end else if (!(&r_quiet)) begin
                        r_quiet <= r_quiet + UMB_W'(1);
                    end
                    if (r_guard != '0) begin
                        r_guard <= r_guard - GW'(1);
                    end
                    // Leak detection wins over both abort and the quiet-timeout exit.
                    if (w_leak) begin
                        r_state <= ST_ERROR;
                        r_idle  <= 1'b1;
                        r_error <= 1'b1;
                    end else if (init) begin
                        r_state <= ST_INIT;
                        r_idle  <= 1'b1;
                    end else if (!w_any_v && w_quiet_hit) begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                        r_quiet <= '0;
                    end
                end
                ST_ERROR: begin
                    r_idle  <= 1'b1;
                    r_error <= 1'b1;
                end
                default: begin
                    r_state <= ST_RESET;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

`ifdef LANE_CNT_EN
    logic [7:0] r_cnt [4];
    logic       w_enter_init;

    assign w_enter_init = (r_state == ST_RESET)
                       || ((r_state == ST_IDLE) && init)
                       || ((r_state == ST_ACTIVE) && !w_leak && init);

    always_ff @(posedge clk_f) begin
        if (reset || w_enter_init) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (r_state == ST_ACTIVE) begin
            for (int i = 0; i < 4; i++) begin
                if (w_valid[i] && (r_cnt[i] != 8'hFF)) r_cnt[i] <= r_cnt[i] + 8'd1;
            end
        end
    end

    assign cnt_0 = r_cnt[0];
    assign cnt_1 = r_cnt[1];
    assign cnt_2 = r_cnt[2];
    assign cnt_3 = r_cnt[3];
`endif

endmodule

// File: tb/tb_phy_tx_ctrl.sv
// Bench for phy_tx_ctrl: directed link scenarios then random traffic against a behavioural model.
// Honours LANE_CNT_EN to also check the per-lane counters.
module tb_phy_tx_ctrl;

    localparam int UMB_W = 4;
    localparam int GUARD = 1;
`ifdef LANE_CNT_EN
    localparam int W = 39;
`else
    localparam int W = 7;
`endif

    logic             clk_f = 1'b0;
    logic             reset = 1'b1;
    logic             init = 1'b0;
    logic [UMB_W-1:0] umbral_idle = '0;
    logic             valid_0 = 0, valid_1 = 0, valid_2 = 0, valid_3 = 0;
    logic             valid_r_0 = 0, valid_r_1 = 0, valid_r_2 = 0, valid_r_3 = 0;
    logic             idle;
    logic [4:0]       state;
    logic             error;
`ifdef LANE_CNT_EN
    logic [7:0]       cnt_0, cnt_1, cnt_2, cnt_3;
`endif

    phy_tx_ctrl #(.UMB_W(UMB_W), .GUARD(GUARD)) dut (
        .clk_f(clk_f), .reset(reset), .init(init), .umbral_idle(umbral_idle),
        .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2), .valid_3(valid_3),
        .valid_r_0(valid_r_0), .valid_r_1(valid_r_1), .valid_r_2(valid_r_2), .valid_r_3(valid_r_3),
        .idle(idle), .state(state), .error(error)
`ifdef LANE_CNT_EN
        , .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
`endif
    );

    always #5 clk_f = ~clk_f;

    // Reference model: link modes 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR.
    int m_mode, m_umb, m_quiet, m_guard, m_err;
    int m_cnt [4];
    logic [W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    function automatic void model_step(input logic rst, input logic ini, input int u,
                                       input logic [3:0] v, input logic [3:0] vr);
        if (rst) begin
            m_mode = 0; m_umb = (1 << UMB_W) - 1; m_quiet = 0; m_guard = 0; m_err = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            return;
        end
        case (m_mode)
            0: m_mode = 1;
            1: begin
                if (ini) m_umb = (u == 0) ? 1 : u;
                else m_mode = 2;
            end
            2: begin
                if (ini) begin
                    m_mode = 1;
                    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                end else if (v != 0) begin
                    m_mode = 3; m_quiet = 0; m_guard = GUARD;
                end
            end
            3: begin
                bit leak;
                bit timeout;
                leak = (m_guard == 0) && (vr != 0);
                timeout = (v == 0) && (m_quiet + 1 == m_umb);
                for (int i = 0; i < 4; i++)
                    if (v[i] && m_cnt[i] < 255) m_cnt[i]++;
                if (m_guard > 0) m_guard--;
                if (v != 0) m_quiet = 0;
                else if (m_quiet < (1 << UMB_W) - 1) m_quiet++;
                if (leak) begin
                    m_mode = 4; m_err = 1;
                end else if (ini) begin
                    m_mode = 1;
                    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                end else if (timeout) begin
                    m_mode = 2; m_quiet = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [4:0] st;
        st = 5'(1 << m_mode);
`ifdef LANE_CNT_EN
        return {st, (m_mode != 3), m_err[0],
                m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
`else
        return {st, (m_mode != 3), m_err[0]};
`endif
    endfunction

    task automatic cyc(input logic rst, input logic ini, input logic [UMB_W-1:0] u,
                       input logic [3:0] v, input logic [3:0] vr);
        @(negedge clk_f);
        reset = rst; init = ini; umbral_idle = u;
        {valid_3, valid_2, valid_1, valid_0} = v;
        {valid_r_3, valid_r_2, valid_r_1, valid_r_0} = vr;
        model_step(rst, ini, int'(u), v, vr);
        exp_q.push_back(model_out());
    endtask

    task automatic cycles(input int n, input logic rst, input logic ini,
                          input logic [UMB_W-1:0] u, input logic [3:0] v, input logic [3:0] vr);
        for (int k = 0; k < n; k++) cyc(rst, ini, u, v, vr);
    endtask

    // Monitor: every edge produces a registered output word; compare it to the queued one.
    initial begin
        logic [W-1:0] act, exp_v;
        forever begin
            @(posedge clk_f);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
`ifdef LANE_CNT_EN
                act = {state, idle, error, cnt_3, cnt_2, cnt_1, cnt_0};
`else
                act = {state, idle, error};
`endif
                checks++;
                if (act !== exp_v) begin
                    errors++;
                    $display("FAIL outputs t=%0t state/idle/error/cnt got %h expected %h",
                             $time, act, exp_v);
                end
            end
        end
    end

    initial begin
        logic       rst, ini;
        logic [3:0] v, vr;
        logic [UMB_W-1:0] u;

        // Reset then INIT with threshold 3; lane 2 busy 5 cycles then quiet.
        cycles(2, 1, 0, 0, 4'h0, 4'h0);
        cyc(0, 0, 0, 4'h0, 4'h0);
        cycles(3, 0, 1, 3, 4'h0, 4'h0);
        cycles(2, 0, 0, 0, 4'h0, 4'h0);
        cycles(5, 0, 0, 0, 4'h4, 4'h0);
        cycles(5, 0, 0, 0, 4'h0, 4'h0);

        // Zero threshold behaves as 1.
        cycles(2, 0, 1, 0, 4'h0, 4'h0);
        cyc(0, 0, 0, 4'h0, 4'h0);
        cycles(3, 0, 0, 0, 4'h1, 4'h0);
        cycles(3, 0, 0, 0, 4'h0, 4'h0);

        // Loopback on entry is legal; guard tolerates first recirc pulse, later one errors.
        cycles(2, 0, 1, 15, 4'h0, 4'h0);
        cyc(0, 0, 0, 4'h0, 4'h0);
        cyc(0, 0, 0, 4'h1, 4'h2);
        cyc(0, 0, 0, 4'h1, 4'h2);
        cycles(2, 0, 0, 0, 4'h1, 4'h0);
        cyc(0, 0, 0, 4'h1, 4'h2);
        cycles(2, 0, 1, 5, 4'h0, 4'h0);
        cycles(2, 0, 0, 5, 4'h0, 4'h0);

        // Reset in the middle of ACTIVE.
        cycles(2, 1, 0, 0, 4'h0, 4'h0);
        cyc(0, 0, 0, 4'h0, 4'h0);
        cyc(0, 0, 0, 4'h0, 4'h0);
        cycles(3, 0, 0, 0, 4'h1, 4'h0);
        cyc(1, 0, 0, 4'h1, 4'h0);
        cycles(2, 0, 0, 0, 4'h0, 4'h0);

        // Long lane-3 burst saturates its counter; abort to INIT clears counts.
        cyc(0, 0, 0, 4'h8, 4'h0);
        cycles(300, 0, 0, 0, 4'h8, 4'h0);
        cycles(2, 0, 1, 2, 4'h0, 4'h0);
        cycles(3, 0, 0, 2, 4'h0, 4'h0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            ini = ($urandom_range(0, 24) == 0);
            u   = UMB_W'($urandom_range(0, (1 << UMB_W) - 1));
            v   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            vr  = (!ini && $urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            cyc(rst, ini, u, v, vr);
        end

        repeat (3) @(negedge clk_f);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
